// File: rtl/conv_pkg.sv
// Shared definitions for the convolution memory sequencer: FSM states,
// memory row assignments and a column helper.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        COMPUTE = 3'd3,
        READ_P1 = 3'd4,
        READ_P2 = 3'd5
    } seq_state_e;

    localparam logic [2:0] ROW_A  = 3'd0;
    localparam logic [2:0] ROW_B  = 3'd1;
    localparam logic [2:0] ROW_P1 = 3'd2;
    localparam logic [2:0] ROW_P2 = 3'd3;

    function automatic logic is_last_col(input logic [7:0] col, input int num_bytes);
        return col == 8'(num_bytes - 1);
    endfunction

endpackage

// File: rtl/out_stage_reg.sv
// Single-entry output register with valid/ready; the data word is frozen
// while a byte is offered and not yet taken.
module out_stage_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       load_last,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       space
);

    logic       valid_r;
    logic [7:0] data_r;
    logic       last_r;

    // Capture a fresh byte or retire the held one on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= 8'h00;
            last_r  <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            last_r  <= load_last;
        end else if (valid_r && out_ready) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_last  = last_r;
    // Register will be free at the end of this cycle
    assign space     = !valid_r || out_ready;

endmodule

// File: rtl/conv_mem_sequencer.sv
// Sequencer that loads two byte vectors into memory rows, starts the adder,
// and streams the two result rows back out with valid/ready flow control.
module conv_mem_sequencer
    import conv_pkg::*;
#(
    parameter int NUM_BYTES = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       err_timeout,
    output logic [2:0] mem_row_addr,
    output logic [7:0] mem_col_addr,
    output logic [7:0] mem_data_in,
    output logic       mem_write,
    output logic       mem_read,
    output logic       mem_en,
    input  logic [7:0] mem_data_out,
    input  logic       mem_done
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    seq_state_e    state_r, state_s;
    logic [7:0]    col_r, col_s;
    logic [TW-1:0] tmo_r, tmo_s;
    logic          rd_done_r, rd_done_s;
    logic          err_r, err_s;
    logic          in_ready_r, in_ready_s;
    logic          busy_r, busy_s;
    logic          mem_write_r, mem_write_s;
    logic          mem_read_r, mem_read_s;
    logic          mem_en_r, mem_en_s;
    logic [2:0]    row_r, row_s;
    logic [7:0]    col_addr_r, col_addr_s;
    logic [7:0]    data_in_r, data_in_s;
    logic          accept_s, space_s, drain_s, load_last_s;

    assign accept_s    = in_valid && in_ready_r;
    assign drain_s     = out_valid && out_ready;
    assign load_last_s = (row_r == ROW_P2) && is_last_col(col_addr_r, NUM_BYTES);

    // Next-state, counter and strobe computation
    always_comb begin
        state_s     = state_r;
        col_s       = col_r;
        tmo_s       = tmo_r;
        rd_done_s   = rd_done_r;
        err_s       = err_r;
        mem_write_s = 1'b0;
        mem_read_s  = 1'b0;
        row_s       = row_r;
        col_addr_s  = col_addr_r;
        data_in_s   = data_in_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = LOAD_A;
                    col_s   = 8'd0;
                    err_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD_A, LOAD_B: begin
                if (accept_s) begin
                    mem_write_s = 1'b1;
                    data_in_s   = in_data;
                    col_addr_s  = col_r;
                    row_s       = (state_r == LOAD_A) ? ROW_A : ROW_B;
                    if (is_last_col(col_r, NUM_BYTES)) begin
                        col_s   = 8'd0;
                        tmo_s   = '0;
                        state_s = (state_r == LOAD_A) ? LOAD_B : COMPUTE;
                    end else begin
                        col_s = col_r + 8'd1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            COMPUTE: begin
                if (mem_done) begin
                    state_s   = READ_P1;
                    col_s     = 8'd0;
                    rd_done_s = 1'b0;
                end else if (tmo_r == TMO_LAST) begin
                    state_s = IDLE;
                    err_s   = 1'b1;
                end else begin
                    tmo_s = tmo_r + 1'b1;
                end
            end
            READ_P1, READ_P2: begin
                // One read in flight at most; it only lands in an empty register
                if ((state_r == READ_P2) && drain_s && out_last) begin
                    state_s = IDLE;
                end else if (!mem_read_r && space_s && !rd_done_r) begin
                    mem_read_s = 1'b1;
                    row_s      = (state_r == READ_P1) ? ROW_P1 : ROW_P2;
                    col_addr_s = col_r;
                    if (is_last_col(col_r, NUM_BYTES)) begin
                        col_s = 8'd0;
                        if (state_r == READ_P1) begin
                            state_s = READ_P2;
                        end else begin
                            rd_done_s = 1'b1;
                        end
                    end else begin
                        col_s = col_r + 8'd1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // Adder start waits one cycle after entry so it never overlaps the final write
        mem_en_s   = (state_r == COMPUTE) && (state_s == COMPUTE);
        in_ready_s = (state_s == LOAD_A) || (state_s == LOAD_B);
        busy_s     = (state_s != IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            col_r       <= 8'd0;
            tmo_r       <= '0;
            rd_done_r   <= 1'b0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            mem_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_en_r    <= 1'b0;
            row_r       <= 3'd0;
            col_addr_r  <= 8'd0;
            data_in_r   <= 8'd0;
        end else begin
            state_r     <= state_s;
            col_r       <= col_s;
            tmo_r       <= tmo_s;
            rd_done_r   <= rd_done_s;
            err_r       <= err_s;
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
            mem_write_r <= mem_write_s;
            mem_read_r  <= mem_read_s;
            mem_en_r    <= mem_en_s;
            row_r       <= row_s;
            col_addr_r  <= col_addr_s;
            data_in_r   <= data_in_s;
        end
    end

    out_stage_reg u_out_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (mem_read_r),
        .load_data (mem_data_out),
        .load_last (load_last_s),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .space     (space_s)
    );

    assign in_ready     = in_ready_r;
    assign busy         = busy_r;
    assign err_timeout  = err_r;
    assign mem_row_addr = row_r;
    assign mem_col_addr = col_addr_r;
    assign mem_data_in  = data_in_r;
    assign mem_write    = mem_write_r;
    assign mem_read     = mem_read_r;
    assign mem_en       = mem_en_r;

endmodule

// File: doc/conv_mem_sequencer.md
CONV_MEM_SEQUENCER -- requirements
Module: conv_mem_sequencer

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 32, meaning bytes per 256-bit vector row (column addresses 0..NUM_BYTES-1).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of cycles to wait for mem_done.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle job request; honoured only in IDLE.
REQ-006 in_valid / in_ready / in_data  in / out / in[7:0]  operand byte stream: NUM_BYTES bytes of vector A, then NUM_BYTES bytes of vector B.
REQ-007 out_valid / out_ready / out_data / out_last  out / in / out[7:0] / out  result byte stream; out_last marks the final byte.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 err_timeout  out  1  sticky flag; set when mem_done does not arrive within TIMEOUT cycles.
REQ-010 mem_row_addr / mem_col_addr / mem_data_in  out[2:0] / out[7:0] / out[7:0]  memory address and write data.
REQ-011 mem_write / mem_read / mem_en  out 1 each  memory write strobe, read strobe, and adder-start level.
REQ-012 mem_data_out / mem_done  in[7:0] / in 1  memory read data and adder completion.

Function
REQ-013 FSM states SHALL be IDLE, LOAD_A, LOAD_B, COMPUTE, READ_P1, READ_P2.
REQ-014 IDLE->LOAD_A on start=1; start SHALL be ignored in all other states.
REQ-015 In LOAD_A and LOAD_B: in_ready=1; each in_valid&in_ready byte SHALL produce, next cycle, a one-cycle mem_write=1 with mem_data_in=byte, mem_col_addr=byte index, and mem_row_addr=0 (A) or 1 (B).
REQ-016 The column counter SHALL wrap to 0 after NUM_BYTES-1; LOAD_A->LOAD_B and LOAD_B->COMPUTE occur on the last accepted byte.
REQ-017 In COMPUTE, mem_en SHALL be held at 1 until the cycle mem_done=1 is sampled, then go to READ_P1 with mem_en=0.
REQ-018 In COMPUTE, a cycle counter SHALL run; on reaching TIMEOUT without mem_done it SHALL set err_timeout, drop mem_en, and return to IDLE.
REQ-019 In READ_P1/READ_P2, a read SHALL be issued (mem_read=1, row 2 or 3, column index) only when the output register is empty or being drained in that cycle.
REQ-020 mem_data_out SHALL be captured one cycle after mem_read into the output register, setting out_valid=1.
REQ-021 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-022 out_last=1 SHALL accompany only row 3, column NUM_BYTES-1; that byte's handshake SHALL return the FSM to IDLE.
REQ-023 mem_write and mem_read SHALL never both be 1, and mem_en SHALL never be 1 together with either.
REQ-024 err_timeout SHALL clear on the next accepted start.
REQ-025 Order on the output stream SHALL be row 2 columns 0..N-1, then row 3 columns 0..N-1; total 2*NUM_BYTES bytes.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, zero all counters, and set all outputs to 0: in_ready, out_valid, out_last, busy, err_timeout, mem_write, mem_read, mem_en, and all address and data outputs.
REQ-027 A reset mid-job SHALL abandon the job with no further memory strobes; the partially written rows are not restored.

Structure
REQ-028 The state enumeration and row constants (ROW_A=0, ROW_B=1, ROW_P1=2, ROW_P2=3) SHALL live in a shared package conv_pkg.
REQ-029 The single output register with valid/ready SHALL be a sub-module named out_stage_reg; the FSM and counters stay in the top.

Verification
REQ-030 Reset during LOAD_B after 10 bytes -> all outputs 0 and busy=0; a new start then reloads from A column 0.
REQ-031 start, stream bytes 0x00..0x1F then 0x20..0x3F -> 64 mem_write pulses: row 0 cols 0..31, then row 1 cols 0..31, with matching data.
REQ-032 Model returns mem_done 5 cycles after mem_en rises -> mem_en high exactly 5 cycles; 64 result bytes out, out_last only on byte 64.
REQ-033 out_ready held 0 for 20 cycles mid-readback -> out_data stable, no mem_read issued, no byte lost or duplicated.
REQ-034 mem_done never asserted, TIMEOUT=16 -> err_timeout=1 after 16 COMPUTE cycles, FSM returns to IDLE, next start clears the flag.
REQ-035 start pulsed during COMPUTE and in_valid=1 in IDLE -> no effect and no mem_write.
